// File: rtl/pmem_arbiter.sv
// Two-to-one I-cache/D-cache arbiter onto a single physical-memory port.
// Optional macro ARB_RR_EN selects round-robin conflict resolution; otherwise the D-cache has fixed priority.
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_pmem_read,
    input  logic              icache_pmem_write,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    input  logic [LINE_W-1:0] icache_pmem_wdata,
    output logic              icache_pmem_resp,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic              dcache_pmem_resp,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   i_req_s;
    logic   d_req_s;
    logic   pick_d_s;

    assign i_req_s = icache_pmem_read | icache_pmem_write;
    assign d_req_s = dcache_pmem_read | dcache_pmem_write;

    // Read data is broadcast; only the resp pulse is qualified by the grant.
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

`ifdef ARB_RR_EN
    logic last_grant_d_r;

    // Remember which cache completed last so the other one wins the next conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d_r <= 1'b0;
        end else if ((state_r == SERVE_I) && pmem_resp) begin
            last_grant_d_r <= 1'b0;
        end else if ((state_r == SERVE_D) && pmem_resp) begin
            last_grant_d_r <= 1'b1;
        end else begin
            last_grant_d_r <= last_grant_d_r;
        end
    end

    assign pick_d_s = ~last_grant_d_r;
`else
    assign pick_d_s = 1'b1;
`endif

    // Grant state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next grant: decide conflicts in IDLE, release on resp or when the owner abandons its request.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    state_nxt_s = pick_d_s ? SERVE_D : SERVE_I;
                end else if (d_req_s) begin
                    state_nxt_s = SERVE_D;
                end else if (i_req_s) begin
                    state_nxt_s = SERVE_I;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp || !i_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp || !d_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVE_D;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Forward the granted cache's request and route the memory resp back to it alone.
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = {ADDR_W{1'b0}};
        pmem_wdata       = {LINE_W{1'b0}};
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        case (state_r)
            SERVE_I: begin
                pmem_read        = icache_pmem_read;
                pmem_write       = icache_pmem_write;
                pmem_address     = icache_pmem_address;
                pmem_wdata       = icache_pmem_wdata;
                icache_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                pmem_read        = dcache_pmem_read;
                pmem_write       = dcache_pmem_write;
                pmem_address     = dcache_pmem_address;
                pmem_wdata       = dcache_pmem_wdata;
                dcache_pmem_resp = pmem_resp;
            end
            default: begin
                pmem_read        = 1'b0;
                pmem_write       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter; inputs driven and outputs sampled 1ns after posedge.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         icache_pmem_read;
    logic         icache_pmem_write;
    logic [15:0]  icache_pmem_address;
    logic [127:0] icache_pmem_wdata;
    logic         icache_pmem_resp;
    logic [127:0] icache_pmem_rdata;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic         dcache_pmem_resp;
    logic [127:0] dcache_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks_cnt = 0;
    int errors_cnt = 0;

    pmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_write   (icache_pmem_write),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_wdata   (icache_pmem_wdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_address        (pmem_address),
        .pmem_wdata          (pmem_wdata),
        .pmem_resp           (pmem_resp),
        .pmem_rdata          (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] i_addr;
    logic [15:0] d_addr;
    logic        exp_d [3];
    logic [127:0] a5_line;

    initial begin
        a5_line = {16{8'hA5}};
        i_addr  = 16'h0100;
        d_addr  = 16'h0200;
`ifdef ARB_RR_EN
        exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
        rst_n = 1'b0;
        icache_pmem_read = 1'b0; icache_pmem_write = 1'b0;
        icache_pmem_address = 16'h0000; icache_pmem_wdata = 128'h0;
        dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        dcache_pmem_address = 16'h0000; dcache_pmem_wdata = 128'h0;
        pmem_resp = 1'b0; pmem_rdata = 128'h0;

        // Reset values
        step(); step();
        check_eq("rst_read", {127'h0, pmem_read}, 128'h0);
        check_eq("rst_write", {127'h0, pmem_write}, 128'h0);
        check_eq("rst_addr", {112'h0, pmem_address}, 128'h0);
        check_eq("rst_resps", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h0);
        rst_n = 1'b1;
        step();

        // Simultaneous reads, three rounds, both held throughout
        icache_pmem_read = 1'b1; icache_pmem_address = i_addr;
        dcache_pmem_read = 1'b1; dcache_pmem_address = d_addr;
        for (int r = 0; r < 3; r++) begin
            step();
            check_eq($sformatf("rr%0d_addr", r), {112'h0, pmem_address},
                     {112'h0, (exp_d[r] ? d_addr : i_addr)});
            pmem_resp = 1'b1;
            #1;
            check_eq($sformatf("rr%0d_resps", r), {126'h0, icache_pmem_resp, dcache_pmem_resp},
                     {126'h0, ~exp_d[r], exp_d[r]});
            step();
            pmem_resp = 1'b0;
            check_eq($sformatf("rr%0d_gap", r), {127'h0, pmem_read}, 128'h0);
        end
        icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
        step();

        // I read only, addr 0x0040, resp at cycle+4
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h0040;
        check_eq("ird_latency", {127'h0, pmem_read}, 128'h0);
        step();
        check_eq("ird_read", {127'h0, pmem_read}, 128'h1);
        check_eq("ird_addr", {112'h0, pmem_address}, 128'h0040);
        step(); step(); step();
        pmem_resp = 1'b1; pmem_rdata = a5_line;
        #1;
        check_eq("ird_resps", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h2);
        check_eq("ird_irdata", icache_pmem_rdata, a5_line);
        check_eq("ird_drdata", dcache_pmem_rdata, a5_line);
        step();
        pmem_resp = 1'b0; icache_pmem_read = 1'b0;
        check_eq("ird_done", {126'h0, pmem_read, icache_pmem_resp}, 128'h0);

        // D write-back 0x1230, held over resp to expose the one-cycle gap
        dcache_pmem_write = 1'b1; dcache_pmem_address = 16'h1230; dcache_pmem_wdata = 128'h1;
        step();
        check_eq("dwb_write", {126'h0, pmem_write, pmem_read}, 128'h2);
        check_eq("dwb_wdata", pmem_wdata, 128'h1);
        check_eq("dwb_addr", {112'h0, pmem_address}, 128'h1230);
        pmem_resp = 1'b1;
        #1;
        check_eq("dwb_resps", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h1);
        step();
        pmem_resp = 1'b0;
        check_eq("dwb_gap", {127'h0, pmem_write}, 128'h0);
        step();
        check_eq("dwb_again", {127'h0, pmem_write}, 128'h1);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0; dcache_pmem_write = 1'b0;
        step();

        // D granted while I waits; I follows after one IDLE cycle
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0300;
        step();
        icache_pmem_read = 1'b1; icache_pmem_address = 16'h0400;
        check_eq("dthen_daddr", {112'h0, pmem_address}, 128'h0300);
        step();
        pmem_resp = 1'b1;
        #1;
        check_eq("dthen_resps", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h1);
        step();
        pmem_resp = 1'b0; dcache_pmem_read = 1'b0;
        check_eq("dthen_idle", {111'h0, pmem_read, pmem_address}, 128'h0);
        step();
        check_eq("dthen_iaddr", {111'h0, pmem_read, pmem_address}, {111'h0, 1'b1, 16'h0400});

        // I abandons its read in SERVE_I
        icache_pmem_read = 1'b0;
        #1;
        check_eq("drop_read", {127'h0, pmem_read}, 128'h0);
        step();
        pmem_resp = 1'b1;
        #1;
        check_eq("drop_idle_addr", {112'h0, pmem_address}, 128'h0);
        check_eq("stray_resp", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h0);
        step();
        pmem_resp = 1'b0;

        // Async reset mid-SERVE_D
        dcache_pmem_read = 1'b1; dcache_pmem_address = 16'h0500;
        step();
        check_eq("rstd_pre", {127'h0, pmem_read}, 128'h1);
        #2;
        rst_n = 1'b0; pmem_resp = 1'b1;
        #1;
        check_eq("rstd_async", {110'h0, pmem_read, dcache_pmem_resp, pmem_address}, 128'h0);
        step();
        rst_n = 1'b1; dcache_pmem_read = 1'b0;
        step();
        check_eq("rstd_noresp", {126'h0, icache_pmem_resp, dcache_pmem_resp}, 128'h0);
        pmem_resp = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
